// File: rtl/mem_responder.sv
// mem_responder: single-outstanding SRAM responder with a fixed response latency.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_addr/req_wen/req_wdata/req_wmask
// request channel; rsp_valid/rsp_ready/rsp_rdata/rsp_err response channel.
// Optional macro MEM_RESP_ERR_EN: out-of-range accesses are flagged instead of aliased.
module mem_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h8000_0000,
    parameter int LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_wen,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFB  = $clog2(BYTES);
    localparam int WORDS = 1 << DEPTH_LOG2;
    // WAIT spends LATENCY-1 cycles, so the counter starts at LATENCY-2.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t stateQ, stateNext;
    logic [3:0] cntQ, cntNext;
    logic accept;

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic [DATA_WIDTH-1:0] rspData;

    logic [ADDR_WIDTH-1:0] offset;
    logic [DEPTH_LOG2-1:0] idx;
    logic inRange;

    assign offset = req_addr - BASE_ADDR;
    assign idx    = DEPTH_LOG2'(offset >> OFFB);

`ifdef MEM_RESP_ERR_EN
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(BYTES) << DEPTH_LOG2;
    logic rspErr;
    assign inRange = (req_addr >= BASE_ADDR) && (offset < MEM_BYTES);
    assign rsp_err = rspErr;
`else
    assign inRange = 1'b1;
    assign rsp_err = 1'b0;
`endif

    assign rsp_rdata = rspData;

    always_comb begin
        stateNext = stateQ;
        cntNext   = cntQ;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        unique case (stateQ)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        stateNext = RESP;
                    end else begin
                        stateNext = WAIT;
                        cntNext   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cntQ == 4'd0) begin
                    stateNext = RESP;
                end else begin
                    cntNext = cntQ - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= IDLE;
            cntQ    <= 4'd0;
            rspData <= '0;
`ifdef MEM_RESP_ERR_EN
            rspErr  <= 1'b0;
`endif
        end else begin
            stateQ <= stateNext;
            cntQ   <= cntNext;
            if (accept) begin
                // Read data is snapshotted here so later writes cannot leak in.
                rspData <= (req_wen || !inRange) ? '0 : mem[idx];
`ifdef MEM_RESP_ERR_EN
                rspErr  <= !inRange;
`endif
            end
        end
    end

    // Array has no reset; writes commit at the accept edge.
    always_ff @(posedge clk) begin
        if (!rst && accept && req_wen && inRange) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_wmask[b]) begin
                    mem[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus for mem_responder with a cycle-level
// reference model of the handshake, latency and memory contents.
module tb_mem_responder;

    localparam int LAT = 2;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wen(req_wen),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: word-addressed associative memory, range rule from the
    // address map, and a countdown to the response cycle.
    logic [63:0] mm [longint];

    function automatic longint wordOf(input logic [63:0] a);
        logic [63:0] o;
        o = a - BASE;
        return longint'((o / 64'd8) % 64'd4096);
    endfunction

    function automatic bit inRng(input logic [63:0] a);
`ifdef MEM_RESP_ERR_EN
        return (a >= BASE) && (a < BASE + 64'd32768);
`else
        return (a == a);
`endif
    endfunction

    bit          started = 1'b0;
    bit          pend = 1'b0;
    int          untilV = 0;
    logic [63:0] expData;
    logic        expErr;

    always @(posedge clk) started <= 1'b1;

    always @(negedge clk) begin
        if (started) begin
            if (pend && untilV > 0) untilV--;
            check("model_req_ready", 64'(req_ready), 64'(!pend));
            check("model_rsp_valid", 64'(rsp_valid), 64'(pend && untilV == 0));
            if (pend && untilV == 0 && rsp_valid) begin
                if (!$isunknown(expData))
                    check("model_rsp_rdata", rsp_rdata, expData);
                check("model_rsp_err", 64'(rsp_err), 64'(expErr));
            end
            if (rst) begin
                pend = 1'b0;
            end else if (!pend && req_valid) begin
                longint w;
                w = wordOf(req_addr);
                expErr = !inRng(req_addr);
                expData = '0;
                if (req_wen) begin
                    if (inRng(req_addr)) begin
                        if (!mm.exists(w)) mm[w] = 'x;
                        for (int b = 0; b < 8; b++)
                            if (req_wmask[b]) mm[w][b*8 +: 8] = req_wdata[b*8 +: 8];
                    end
                end else if (inRng(req_addr)) begin
                    expData = mm.exists(w) ? mm[w] : 'x;
                end
                pend = 1'b1;
                untilV = LAT;
            end else if (pend && untilV == 0 && rsp_ready) begin
                pend = 1'b0;
            end
        end
    end

    task automatic xact(input logic [63:0] a, input bit wen,
                        input logic [63:0] wd, input logic [7:0] wm,
                        input int stall, output logic [63:0] rd,
                        output logic er, output int lat);
        bit got;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a; req_wen = wen;
        req_wdata = wd; req_wmask = wm;
        rsp_ready = (stall == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0; lat = 0; rd = '0; er = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k; got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("rsp_timeout", 64'(got), 64'd1);
        end else begin
            rd = rsp_rdata; er = rsp_err;
            if (stall > 0) begin
                repeat (stall) begin
                    @(negedge clk);
                    check("stall_valid", 64'(rsp_valid), 64'd1);
                    check("stall_rdata", rsp_rdata, rd);
                    check("stall_req_ready", 64'(req_ready), 64'd0);
                end
                @(posedge clk); #1;
                rsp_ready = 1'b1;
                @(negedge clk);
                check("consume_cycle_valid", 64'(rsp_valid), 64'd1);
            end
            @(negedge clk);
            check("after_rsp_ready", 64'(req_ready), 64'd1);
            check("after_rsp_valid", 64'(rsp_valid), 64'd0);
        end
    endtask

    logic [63:0] rd;
    logic er;
    int lat;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_req_ready", 64'(req_ready), 64'd1);
            check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready", 64'(req_ready), 64'd1);
        check("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);

        xact(64'h8000_0008, 1'b1, 64'h1122334455667788, 8'hFF, 0, rd, er, lat);
        check("write_latency", 64'(lat), 64'd2);
        check("write_rdata_zero", rd, 64'd0);
        xact(64'h8000_0008, 1'b0, 64'd0, 8'h00, 0, rd, er, lat);
        check("read_latency", 64'(lat), 64'd2);
        check("read_full", rd, 64'h1122334455667788);

        xact(64'h8000_0008, 1'b1, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, rd, er, lat);
        xact(64'h8000_0008, 1'b0, 64'd0, 8'h00, 0, rd, er, lat);
        check("read_partial", rd, 64'h11223344AAAAAAAA);

        xact(64'h8000_0008, 1'b1, 64'h5555555555555555, 8'h00, 0, rd, er, lat);
        check("mask0_latency", 64'(lat), 64'd2);
        xact(64'h8000_0008, 1'b0, 64'd0, 8'h00, 5, rd, er, lat);
        check("read_stalled", rd, 64'h11223344AAAAAAAA);

        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 64'h8000_0010; req_wen = 1'b1;
        req_wdata = 64'hCAFEF00D12345678; req_wmask = 8'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_wait_valid", 64'(rsp_valid), 64'd0);
            check("rst_wait_ready", 64'(req_ready), 64'd1);
        end
        xact(64'h8000_0010, 1'b0, 64'd0, 8'h00, 0, rd, er, lat);
        check("read_after_rst", rd, 64'hCAFEF00D12345678);

        xact(64'h8000_7FF8, 1'b1, 64'h0123456789ABCDEF, 8'hFF, 0, rd, er, lat);
        xact(64'h7FFF_FFF8, 1'b0, 64'd0, 8'h00, 0, rd, er, lat);
`ifdef MEM_RESP_ERR_EN
        check("oor_read_rdata", rd, 64'd0);
        check("oor_read_err", 64'(er), 64'd1);
`else
        check("alias_read_rdata", rd, 64'h0123456789ABCDEF);
        check("alias_read_err", 64'(er), 64'd0);
`endif
        xact(64'h7FFF_FFF8, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, rd, er, lat);
        xact(64'h8000_7FF8, 1'b0, 64'd0, 8'h00, 0, rd, er, lat);
`ifdef MEM_RESP_ERR_EN
        check("oor_write_no_change", rd, 64'h0123456789ABCDEF);
`else
        check("alias_write_hits_top", rd, 64'hFFFFFFFFFFFFFFFF);
`endif
        check("top_word_err", 64'(er), 64'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
